ysyx_23060187_alu_mc: RTL
=========================

// Module: ysyx_23060187_alu_mc
// PURPOSE
//   Parametrised, handshaked EX-stage ALU: single-cycle logic/arith/shift/compare ops
//   plus optional iterative unsigned multiply/divide. Sits between the decoder/regfile
//   read and writeback. Keeps the legacy 4-bit op codes 0/1/2/6 (AND/OR/ADD/SUB).
//   Adds valid/ready flow control so multi-cycle ops can stall the pipeline.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; legal range >=4
//   CTRL_W  4   width of alu_ctrl
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       operation request valid
//   in_ready   out  1       block can accept a request (state==IDLE)
//   alu_ctrl   in   CTRL_W  operation select (encoding below)
//   opnum1     in   WIDTH   operand A
//   opnum2     in   WIDTH   operand B
//   out_valid  out  1       result valid (state==DONE)
//   out_ready  in   1       consumer takes result
//   result     out  WIDTH   registered result, held stable while out_valid && !out_ready
//   zero       out  1       (result==0); meaningful only while out_valid
//   busy       out  1       state==BUSY (multi-cycle iteration in progress)
// BEHAVIOUR
//   Ops: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT (signed), 8 SLTU,
//     9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits), 12 DIVU, 13 REMU;
//     14,15 -> result 0. ADD/SUB wrap modulo 2^WIDTH. Shift amount = opnum2[$clog2(WIDTH)-1:0].
//     SLT/SLTU result is zero-extended 1/0.
//   Reset: state=IDLE, result=0, out_valid=0, busy=0, in_ready=1, counter=0.
//   FSM IDLE -> (in_valid, single-cycle op) -> DONE; result registered at the accept edge.
//       IDLE -> (in_valid, op 10-13) -> BUSY; operands latched, cnt=0.
//       BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle, cnt++;
//             step with cnt==WIDTH-1 writes result and goes DONE. BUSY lasts exactly WIDTH cycles.
//       DONE: out_valid=1; on out_ready -> IDLE (next accept earliest the following cycle).
//   Latency (accept edge N): single-cycle ops out_valid after edge N; MUL/DIV after edge N+WIDTH.
//   in_valid ignored unless IDLE; operands may change freely after accept.
//   DIVU/REMU by zero: no iteration, IDLE->DONE in 1 cycle; DIVU = all ones, REMU = opnum1.
//   out_ready while not out_valid: ignored. Unknown op in BUSY impossible (latched).
//   rst asserted mid-BUSY/DONE: immediate return to reset values; in-flight op discarded.
// CONFIGURATION
//   ALU_MULDIV_EN defined: ops 10-13 implemented as above (BUSY state, counter, datapath).
//   ALU_MULDIV_EN undefined: no iterative datapath; ops 10-13 treated as single-cycle,
//     result 0; busy tied 0; all other timing unchanged.
// TESTING
//   Reset mid-op: start MUL, assert rst at cnt=5 -> out_valid=0, in_ready=1, result=0 at once.
//   ADD 0xFFFFFFFF+1 (WIDTH=32) -> out_valid next cycle, result=0, zero=1; SUB 5-7 -> 0xFFFFFFFE.
//   SLT 0x80000000,1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
//   MUL 0x10000*0x10000 -> after 32 cycles result 0; MULHU same -> 1; busy high for 32 cycles.
//   DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF in 1 cycle, REMU 9/0 -> 9.
//   Backpressure: out_ready=0 for 3 cycles -> result/out_valid held, in_ready=0, new in_valid ignored.

Source files
------------

// File: rtl/ysyx_23060187_alu_mc.sv
// rtl/ysyx_23060187_alu_mc.sv - handshaked EX-stage ALU; iterative MUL/MULHU/DIVU/REMU when ALU_MULDIV_EN is defined
module ysyx_23060187_alu_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  opnum1,
  input  logic [WIDTH-1:0]  opnum2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_XOR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SLL   = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SRL   = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_SLTU  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_SRA   = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OP_MUL   = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] OP_MULHU = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] OP_REMU  = CTRL_W'(13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  w_alu_res;
  logic [SH_W-1:0]   w_shamt;
  logic              w_accept;
  logic              w_start_md;
  logic              w_last;

  assign w_shamt  = opnum2[SH_W-1:0];
  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_comb begin
    w_alu_res = '0;
    case (alu_ctrl)
      OP_AND:  w_alu_res = opnum1 & opnum2;
      OP_OR:   w_alu_res = opnum1 | opnum2;
      OP_ADD:  w_alu_res = opnum1 + opnum2;
      OP_XOR:  w_alu_res = opnum1 ^ opnum2;
      OP_SLL:  w_alu_res = opnum1 << w_shamt;
      OP_SRL:  w_alu_res = opnum1 >> w_shamt;
      OP_SUB:  w_alu_res = opnum1 - opnum2;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(opnum1) < $signed(opnum2))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (opnum1 < opnum2)};
      OP_SRA:  w_alu_res = $unsigned($signed(opnum1) >>> w_shamt);
`ifdef ALU_MULDIV_EN
      // Only reached with a zero divisor; nonzero divisors iterate in BUSY.
      OP_DIVU: w_alu_res = '1;
      OP_REMU: w_alu_res = opnum1;
`endif
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [SH_W-1:0]   r_cnt;
  logic [CTRL_W-1:0] r_op;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_shf;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_hi_n;
  logic [WIDTH-1:0]  w_lo_n;
  logic [WIDTH-1:0]  w_md_res;
  logic              w_in_mul;
  logic              w_op_mul;

  assign w_in_mul   = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MULHU);
  assign w_op_mul   = (r_op == OP_MUL) || (r_op == OP_MULHU);
  assign w_start_md = w_in_mul ||
                      (((alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU)) && (opnum2 != '0));
  assign w_last     = (r_cnt == SH_W'(WIDTH-1));

  // {r_hi,r_lo} is the product (multiplier consumed from r_lo's LSB) or remainder/quotient pair.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_shf  = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_shf - {1'b0, r_opb};
    if (w_op_mul) begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_n = w_diff[WIDTH] ? w_shf[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
    w_md_res = ((r_op == OP_MUL) || (r_op == OP_DIVU)) ? w_lo_n : w_hi_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_opb <= '0;
    end else if (w_accept && w_start_md) begin
      r_cnt <= '0;
      r_op  <= alu_ctrl;
      r_hi  <= '0;
      r_lo  <= w_in_mul ? opnum2 : opnum1;
      r_opb <= w_in_mul ? opnum1 : opnum2;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
    end
  end

  assign busy = (r_state == S_BUSY);
`else
  assign w_start_md = 1'b0;
  assign w_last     = 1'b1;
  assign busy       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_n = w_start_md ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_n = S_DONE;
      S_DONE:  if (out_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_accept && !w_start_md) begin
      r_result <= w_alu_res;
`ifdef ALU_MULDIV_EN
    end else if ((r_state == S_BUSY) && w_last) begin
      r_result <= w_md_res;
`endif
    end
  end

  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

endmodule
